// File: rtl/quad_decoder_ext.sv
// Quadrature decoder: sync, glitch filter, step decode, clear, velocity.
// Optional index input enabled by defining QUAD_INDEX_EN.
module quad_decoder_ext #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_PERIOD  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quadA,
  input  logic             quadB,
`ifdef QUAD_INDEX_EN
  input  logic             quadI,
`endif
  input  logic             clear,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             err,
  output logic [CNT_W-1:0] velocity,
  output logic             vel_valid
`ifdef QUAD_INDEX_EN
  ,
  output logic             index_hit
`endif
);

`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
  logic [NCH-1:0] w_pin;
  assign w_pin = {quadI, quadB, quadA};
`else
  localparam int NCH = 2;
  logic [NCH-1:0] w_pin;
  assign w_pin = {quadB, quadA};
`endif

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int PW = $clog2(SYNC_STAGES + FILT_LEN + 1);
  localparam int WW = $clog2(VEL_PERIOD);

  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [FW-1:0]          r_fcnt [NCH];
  logic [NCH-1:0]         r_filt;
  logic [NCH-1:0]         r_fd;
  logic [NCH-1:0]         w_syn;
  logic [PW-1:0]          r_pcnt;
  logic                   r_primed;
  logic [WW-1:0]          r_win;
  logic [CNT_W-1:0]       r_acc;

  logic             w_prime_now;
  logic             w_up;
  logic             w_dn;
  logic             w_ill;
  logic             w_win_end;
  logic             w_zero;
  logic [CNT_W-1:0] w_step;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_syn[c] = r_sync[c][SYNC_STAGES-1];
    end
  end

  assign w_prime_now = !r_primed &&
    (r_pcnt == PW'(SYNC_STAGES + FILT_LEN - 1));

  // Step decode compares the previous filtered {A,B} with the current one
  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    unique case ({r_fd[0], r_fd[1], r_filt[0], r_filt[1]})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_up = r_primed;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: w_dn = r_primed;
      default: ;
    endcase
  end

  assign w_ill = r_primed
    & (r_fd[0] ^ r_filt[0])
    & (r_fd[1] ^ r_filt[1]);

  always_comb begin
    w_step = '0;
    if (w_up) begin
      w_step = CNT_W'(1);
    end else if (w_dn) begin
      w_step = '1;
    end
  end

  assign w_win_end = (r_win == WW'(VEL_PERIOD - 1));

`ifdef QUAD_INDEX_EN
  logic w_idx;
  assign w_idx  = r_primed & r_filt[2] & ~r_fd[2];
  assign w_zero = clear | w_idx;
`else
  assign w_zero = clear;
`endif

  // Input conditioning: synchroniser, filter and priming
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_sync[c] <= '0;
        r_fcnt[c] <= '0;
      end
      r_filt   <= '0;
      r_fd     <= '0;
      r_pcnt   <= '0;
      r_primed <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_pin[c]};
      end
      if (!r_primed) begin
        for (int c = 0; c < NCH; c++) begin
          r_fcnt[c] <= '0;
        end
        r_pcnt <= r_pcnt + 1'b1;
        if (w_prime_now) begin
          r_filt   <= w_syn;
          r_fd     <= w_syn;
          r_primed <= 1'b1;
        end
      end else begin
        r_fd <= r_filt;
        for (int c = 0; c < NCH; c++) begin
          if (w_syn[c] == r_filt[c]) begin
            r_fcnt[c] <= '0;
          end else if (r_fcnt[c] == FW'(FILT_LEN - 1)) begin
            r_filt[c] <= w_syn[c];
            r_fcnt[c] <= '0;
          end else begin
            r_fcnt[c] <= r_fcnt[c] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      dir       <= 1'b0;
      err       <= 1'b0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      r_win     <= '0;
      r_acc     <= '0;
    end else begin
      if (w_zero) begin
        count <= '0;
      end else begin
        count <= count + w_step;
      end
      if (w_up) begin
        dir <= 1'b1;
      end else if (w_dn) begin
        dir <= 1'b0;
      end
      if (w_ill) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      vel_valid <= w_win_end;
      if (w_win_end) begin
        velocity <= r_acc + w_step;
        r_acc    <= '0;
        r_win    <= '0;
      end else begin
        r_acc <= r_acc + w_step;
        r_win <= r_win + 1'b1;
      end
    end
  end

`ifdef QUAD_INDEX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      index_hit <= 1'b0;
    end else begin
      index_hit <= w_idx;
    end
  end
`endif

endmodule
